// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// Optional feature macro: DIV_ZERO_EXC_EN (zero divisor exits early with DivZero).
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Two's complement negate when n is set; magnitude of 0x80000000 stays 0x80000000.
  function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] x,
                                                     input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One unsigned restoring-division iteration (purely combinational).
// Macro DIV_ZERO_EXC_EN has no effect here.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_div,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  logic [W:0]   w_shift;
  logic [W-1:0] w_diff;
  logic         w_ge;

  // Shift {rem,quo} left, trial-subtract; the partial remainder needs one extra
  // bit for the compare, but a successful subtraction always fits in W bits.
  always_comb begin
    w_shift = {i_rem, i_quo[W-1]};
    w_ge    = (w_shift >= {1'b0, i_div});
    w_diff  = w_shift[W-1:0] - i_div;
    o_rem   = w_ge ? w_diff : w_shift[W-1:0];
    o_quo   = {i_quo[W-2:0], w_ge};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider (MIPS DIV semantics): quotient to LO, remainder to HI.
// Sequence: IDLE -> LOAD -> RUN x32 -> FIX -> DONE; DivCtrl low aborts or releases.
// Macro DIV_ZERO_EXC_EN: when defined, a zero divisor goes LOAD -> DONE with DivZero=1;
// when undefined, DivZero is tied low and the datapath runs unmodified.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] RegAOut,
  input  logic [WIDTH-1:0] RegBOut,
  input  logic             DivCtrl,
  output logic             DivDone,
  output logic             DivZero,
  output logic [WIDTH-1:0] DivHIOut,
  output logic [WIDTH-1:0] DivLOOut,
  output logic [5:0]       counter
);

  div_state_e       r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_quo, r_div;
  logic             r_sa, r_sb;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done;
  logic [WIDTH-1:0] w_rem_nx, w_quo_nx;
  logic             w_last;

`ifdef DIV_ZERO_EXC_EN
  logic             r_zero;
  logic             w_div_zero;
  assign w_div_zero = (r_div == '0);
  assign DivZero    = r_zero;
`else
  assign DivZero    = 1'b0;
`endif

  assign w_last   = (r_cnt == 6'(DIV_ITERS - 1));
  assign DivDone  = r_done;
  assign DivHIOut = r_hi;
  assign DivLOOut = r_lo;
  assign counter  = r_cnt;

  div_step #(.W(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  // State register; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state; DivCtrl low anywhere past IDLE returns to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (DivCtrl) w_next = LOAD;
      LOAD: begin
        if (!DivCtrl) w_next = IDLE;
`ifdef DIV_ZERO_EXC_EN
        else if (w_div_zero) w_next = DONE;
`endif
        else w_next = RUN;
      end
      RUN: begin
        if (!DivCtrl)    w_next = IDLE;
        else if (w_last) w_next = FIX;
      end
      FIX:  w_next = DivCtrl ? DONE : IDLE;
      DONE: if (!DivCtrl) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture magnitudes and signs, iterate, sign-fix into HI/LO.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      r_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (DivCtrl) begin
            r_sa  <= RegAOut[WIDTH-1];
            r_sb  <= RegBOut[WIDTH-1];
            r_quo <= cond_neg(RegAOut, RegAOut[WIDTH-1]);
            r_div <= cond_neg(RegBOut, RegBOut[WIDTH-1]);
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        LOAD: begin
`ifdef DIV_ZERO_EXC_EN
          if (DivCtrl && w_div_zero) begin
            r_done <= 1'b1;
            r_zero <= 1'b1;
          end
`endif
        end
        RUN: begin
          if (DivCtrl) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 6'd1;
          end
        end
        FIX: begin
          if (DivCtrl) begin
            r_lo   <= cond_neg(r_quo, r_sa ^ r_sb);
            r_hi   <= cond_neg(r_rem, r_sa);
            r_done <= 1'b1;
          end
        end
        DONE: begin
          if (!DivCtrl) begin
            r_done <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
            r_zero <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, reset and abort
// mid-operation, then random operands against a signed-arithmetic model.
// Honours DIV_ZERO_EXC_EN the same way as the design.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] RegAOut = '0;
  logic [31:0] RegBOut = '0;
  logic        DivCtrl = 1'b0;
  logic        DivDone, DivZero;
  logic [31:0] DivHIOut, DivLOOut;
  logic [5:0]  counter;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .RegAOut(RegAOut), .RegBOut(RegBOut),
    .DivCtrl(DivCtrl), .DivDone(DivDone), .DivZero(DivZero),
    .DivHIOut(DivHIOut), .DivLOOut(DivLOOut), .counter(counter)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // MIPS DIV reference: truncating quotient, remainder follows dividend sign.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    int sa, sb;
    sa = a;
    sb = b;
    z  = 1'b0;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_EXC_EN
      z = 1'b1;
      q = exp_lo;
      r = exp_hi;
`else
      r = a;
      q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
`endif
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  // Full operation: start, scramble operands after capture, wait for done,
  // check results/latency, check hold, then release and check the IDLE return.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    logic z;
    int edges, lat;
    model(a, b, q, r, z);
    lat = z ? 1 : 34;
    RegAOut = a;
    RegBOut = b;
    DivCtrl = 1'b1;
    tick();
    RegAOut = $urandom;
    RegBOut = $urandom;
    edges = 0;
    while (!DivDone && edges < 60) begin
      tick();
      edges++;
    end
    chk("latency", 32'(edges), 32'(lat));
    chk("lo", DivLOOut, q);
    chk("hi", DivHIOut, r);
    chk("zero", {31'd0, DivZero}, {31'd0, z});
    chk("cnt", {26'd0, counter}, z ? 32'd0 : 32'd32);
    tick();
    chk("hold_done", {31'd0, DivDone}, 32'd1);
    chk("hold_lo", DivLOOut, q);
    DivCtrl = 1'b0;
    tick();
    chk("rel_done", {31'd0, DivDone}, 32'd0);
    chk("rel_zero", {31'd0, DivZero}, 32'd0);
    chk("rel_lo", DivLOOut, q);
    chk("rel_hi", DivHIOut, r);
    exp_lo = q;
    exp_hi = r;
  endtask

  // Start an operation and stop once counter reaches n (bounded).
  task automatic start_until(input logic [31:0] a, input logic [31:0] b, input int n);
    int k;
    RegAOut = a;
    RegBOut = b;
    DivCtrl = 1'b1;
    tick();
    k = 0;
    while (counter != 6'(n) && k < 60) begin
      tick();
      k++;
    end
    chk("reach_cnt", {26'd0, counter}, 32'(n));
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_done", {31'd0, DivDone}, 32'd0);
    chk("rst_zero", {31'd0, DivZero}, 32'd0);
    chk("rst_hi", DivHIOut, 32'd0);
    chk("rst_lo", DivLOOut, 32'd0);
    chk("rst_cnt", {26'd0, counter}, 32'd0);
    reset = 1'b0;
    tick();

    run_op(32'd100, 32'd7);
    run_op(-32'sd100, 32'd7);
    run_op(32'd100, -32'sd7);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'd5, 32'd0);
    run_op(-32'sd5, 32'd0);
    run_op(32'd0, 32'd5);
    run_op(32'd7, 32'd100);
    run_op(32'hFFFF_FFFF, 32'd1);
    run_op(32'h8000_0000, 32'd1);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_op(32'h8000_0000, 32'h8000_0000);

    // Reset in the middle of RUN clears everything; the next op is clean.
    start_until(32'd1234567, 32'd89, 10);
    reset   = 1'b1;
    DivCtrl = 1'b0;
    tick();
    chk("mid_rst_done", {31'd0, DivDone}, 32'd0);
    chk("mid_rst_hi", DivHIOut, 32'd0);
    chk("mid_rst_lo", DivLOOut, 32'd0);
    chk("mid_rst_cnt", {26'd0, counter}, 32'd0);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    tick();
    run_op(32'd9, 32'd3);

    // Abort mid-RUN keeps the previous results and leaves DivDone low.
    start_until(32'd1000, 32'd33, 20);
    DivCtrl = 1'b0;
    tick();
    chk("abort_done", {31'd0, DivDone}, 32'd0);
    chk("abort_lo", DivLOOut, exp_lo);
    chk("abort_hi", DivHIOut, exp_hi);
    tick();
    chk("abort_idle_done", {31'd0, DivDone}, 32'd0);
    run_op(32'd1000, 32'd33);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(1, 15));
        1:       rb = -32'($urandom_range(1, 15));
        2:       rb = 32'($urandom_range(0, 2)) == 0 ? 32'd0 : $urandom;
        default: rb = $urandom;
      endcase
      run_op(ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
